ps2_temp_entry: RTL and testbench
=================================

Name: ps2_temp_entry

Overview:
- Upstream stage of DecoTemps. Receives PS/2 keyboard frames and captures a two-digit temperature setpoint typed as tens, then units, then Enter.
- Presents the raw scan codes on DECENAS/UNIDADES, which DecoTemps decodes into TempDecsalida.
- Outputs hold the last committed pair until the next commit.

Parameters:
- FILTER_LEN, 8: number of consecutive equal CLK samples required before the filtered ps2_clk level changes.
- TIMEOUT_CYC, 100000: CLK cycles with no ps2_clk falling edge mid-frame before the receiver aborts to IDLE (1 ms at 100 MHz).

Ports:
- CLK  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ps2_clk  in  1  PS/2 clock from keyboard, asynchronous.
- ps2_data  in  1  PS/2 data from keyboard, asynchronous.
- DECENAS  out  8  committed tens-digit scan code.
- UNIDADES  out  8  committed units-digit scan code.
- valid  out  1  one-cycle pulse on the cycle DECENAS/UNIDADES update.
- frame_err  out  1  one-cycle pulse on parity error, stop-bit error or timeout.

Behaviour:
- Reset: all of the following are 0: DECENAS, UNIDADES, valid, frame_err, break_flag, ext_flag. Receiver FSM goes to IDLE; entry FSM goes to WAIT_TENS. Reset takes effect immediately, including mid-frame or mid-entry. No partial entry survives reset.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - ps2_clk then passes through the FILTER_LEN glitch filter.
  - A falling edge of the filtered clock gives a one-cycle fall strobe, and ps2_data is sampled on that strobe.
- Receiver FSM (IDLE, DATA, PARITY, STOP):
  - IDLE: fall with data=0 goes to DATA and clears the bit count. Fall with data=1 is ignored.
  - DATA: shift in 8 bits, LSB first. After the 8th bit, go to PARITY.
  - PARITY: check odd parity; the count of ones over the data bits plus the parity bit must be odd. Go to STOP.
  - STOP: the stop bit must be 1. If stop and parity are both good, pulse byte_rdy for one cycle with the byte; otherwise pulse frame_err. Return to IDLE.
  - Timeout: a counter resets on every fall. In any state other than IDLE, reaching TIMEOUT_CYC pulses frame_err and returns to IDLE; no byte is produced.
- Byte filter (applied on byte_rdy):
  - 0xE0 sets ext_flag.
  - 0xF0 sets break_flag.
  - Any other byte: if break_flag or ext_flag is set, the byte is discarded and both flags clear. Otherwise the byte is a key "make" event and goes to the entry FSM.
  - Key repeats are accepted as fresh makes.
- Digit set: 0x45, 0x16, 0x1E, 0x26, 0x25, 0x2E, 0x36, 0x3D, 0x3E, 0x46 (keys 0-9).
- Entry FSM (WAIT_TENS, WAIT_UNITS, WAIT_ENTER):
  - WAIT_TENS: a digit make latches tens_tmp and goes to WAIT_UNITS.
  - WAIT_UNITS: a digit make latches units_tmp and goes to WAIT_ENTER.
  - WAIT_ENTER: Enter (0x5A) copies tens_tmp to DECENAS and units_tmp to UNIDADES, pulses valid, and returns to WAIT_TENS. A further digit overwrites units_tmp and stays in WAIT_ENTER.
  - Esc (0x76), in any state, goes to WAIT_TENS with no output change.
  - Backspace (0x66): from WAIT_ENTER go to WAIT_UNITS; from WAIT_UNITS go to WAIT_TENS; in WAIT_TENS it is ignored.
  - Any other make is ignored, as is Enter outside WAIT_ENTER.
- Latency: valid and the output update occur 2 CLK cycles after the fall strobe of the Enter frame's stop bit (1 cycle for byte_rdy, 1 cycle to register the outputs).
- Simultaneous events: frame_err and byte_rdy cannot coincide. A byte completing on the same cycle the timeout expires is treated as a timeout.

Decomposition:
- Shared package ps2_pkg holds:
  - scan-code constants: SC_0..SC_9, SC_ENTER=0x5A, SC_ESC=0x76, SC_BKSP=0x66, SC_BREAK=0xF0, SC_EXT=0xE0;
  - the is_digit function;
  - the state enums for both FSMs.
- Sub-module ps2_rx_byte contains the synchronizer, filter, receiver FSM and timeout. Its outputs are byte[7:0], byte_rdy and frame_err.
- The top level contains the byte filter, the entry FSM and the output registers.

Test Plan:
- Reset: hold reset=0 for 50 ns mid-frame, then release -> DECENAS=0x00, UNIDADES=0x00, valid=0, FSMs idle. The next clean frame is received correctly.
- Basic entry: frames 0x1E, F0 1E, 0x16, F0 16, 0x5A -> one valid pulse with DECENAS=0x1E, UNIDADES=0x16 ("21"). No output change before Enter.
- Parity error: send 0x46 with parity bit=1 (invalid, since 0x46 has three ones) -> frame_err pulse, entry state unchanged. A following good 0x46 frame is accepted.
- Timeout: stop ps2_clk after 4 data bits for more than TIMEOUT_CYC cycles -> frame_err pulse, receiver IDLE. Frames 0x3E, 0x26, 0x5A then give DECENAS=0x3E, UNIDADES=0x26.
- Editing: frames 0x45, 0x3D, 0x66, 0x25, 0x5A -> DECENAS=0x45, UNIDADES=0x25. Esc after 0x36 followed by 0x5A -> no valid pulse, outputs hold previous values.
- Break/extended handling: frames E0 5A (keypad Enter), then F0 16 -> no FSM effect. A 6 ns glitch on ps2_clk -> no bit sampled.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan codes, digit classifier and FSM state types for the PS/2
// temperature-entry front end.
package ps2_pkg;

  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {WAIT_TENS, WAIT_UNITS, WAIT_ENTER} entry_state_e;

  function automatic logic is_digit(input logic [7:0] code);
    case (code)
      SC_0, SC_1, SC_2, SC_3, SC_4,
      SC_5, SC_6, SC_7, SC_8, SC_9: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_temp_entry_if.sv
// Keyboard-side inputs and committed-setpoint outputs of ps2_temp_entry.
interface ps2_temp_entry_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] DECENAS;
  logic [7:0] UNIDADES;
  logic       valid;
  logic       frame_err;

  modport master (output ps2_clk, ps2_data, input DECENAS, UNIDADES, valid, frame_err);
  modport slave  (input ps2_clk, ps2_data, output DECENAS, UNIDADES, valid, frame_err);
endinterface

// File: rtl/ps2_rx_byte.sv
// PS/2 byte receiver: synchronizer, clock glitch filter, framing FSM with
// odd-parity/stop checks and a mid-frame inactivity timeout.
module ps2_rx_byte
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_rdy,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic          filt_d, filt_q, filt_prev_q;
  logic [FW-1:0] fcnt_d, fcnt_q;
  logic          fall;

  rx_state_e     state_d, state_q;
  logic [2:0]    bits_d, bits_q;
  logic [7:0]    shift_d, shift_q;
  logic          par_ok_d, par_ok_q;
  logic [TW-1:0] to_d, to_q;
  logic [7:0]    byte_d, byte_q;
  logic          rdy_d, rdy_q, err_d, err_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      data_s1_q   <= 1'b1;
      data_s2_q   <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= RX_IDLE;
      bits_q      <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      to_q        <= '0;
      byte_q      <= '0;
      rdy_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      data_s1_q   <= ps2_data;
      data_s2_q   <= data_s1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bits_q      <= bits_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      to_q        <= to_d;
      byte_q      <= byte_d;
      rdy_q       <= rdy_d;
      err_q       <= err_d;
    end
  end

  // Filtered level flips only on the FILTER_LEN-th consecutive disagreeing sample.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                               fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  always_comb begin
    state_d  = state_q;
    bits_d   = bits_q;
    shift_d  = shift_q;
    par_ok_d = par_ok_q;
    byte_d   = byte_q;
    rdy_d    = 1'b0;
    err_d    = 1'b0;
    if (state_q == RX_IDLE || fall) to_d = '0;
    else                            to_d = to_q + 1'b1;

    // Timeout wins over a byte completing on the same cycle.
    if (state_q != RX_IDLE && to_q == TW'(TIMEOUT_CYC - 1)) begin
      err_d   = 1'b1;
      state_d = RX_IDLE;
      to_d    = '0;
    end else if (fall) begin
      case (state_q)
        RX_IDLE: if (!data_s2_q) begin
          state_d = RX_DATA;
          bits_d  = '0;
        end
        RX_DATA: begin
          shift_d = {data_s2_q, shift_q[7:1]};
          bits_d  = bits_q + 1'b1;
          if (bits_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_ok_d = ^{shift_q, data_s2_q};
          state_d  = RX_STOP;
        end
        RX_STOP: begin
          if (data_s2_q && par_ok_q) begin
            rdy_d  = 1'b1;
            byte_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign rx_byte   = byte_q;
  assign byte_rdy  = rdy_q;
  assign frame_err = err_q;

endmodule

// File: rtl/ps2_temp_entry.sv
// Captures a two-digit setpoint typed as tens, units, Enter and holds the
// committed pair of scan codes for DecoTemps.
module ps2_temp_entry
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic             CLK,
  input logic             reset,
  ps2_temp_entry_if.slave bus
);

  logic [7:0]   rx_byte;
  logic         byte_rdy, rx_err;
  logic         ext_d, ext_q, brk_d, brk_q, make;
  entry_state_e entry_d, entry_q;
  logic [7:0]   tens_d, tens_q, units_d, units_q, dec_d, dec_q, uni_d, uni_q;
  logic         valid_d, valid_q;

  ps2_rx_byte #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .CLK      (CLK),
    .reset    (reset),
    .ps2_clk  (bus.ps2_clk),
    .ps2_data (bus.ps2_data),
    .rx_byte  (rx_byte),
    .byte_rdy (byte_rdy),
    .frame_err(rx_err)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      entry_q <= WAIT_TENS;
      tens_q  <= '0;
      units_q <= '0;
      dec_q   <= '0;
      uni_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      entry_q <= entry_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      dec_q   <= dec_d;
      uni_q   <= uni_d;
      valid_q <= valid_d;
    end
  end

  // The byte following a break or extended prefix is swallowed, not a make.
  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    make    = 1'b0;
    entry_d = entry_q;
    tens_d  = tens_q;
    units_d = units_q;
    dec_d   = dec_q;
    uni_d   = uni_q;
    valid_d = 1'b0;

    if (byte_rdy) begin
      if (rx_byte == SC_EXT)        ext_d = 1'b1;
      else if (rx_byte == SC_BREAK) brk_d = 1'b1;
      else if (ext_q || brk_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else begin
        make = 1'b1;
      end
    end

    if (make) begin
      if (rx_byte == SC_ESC) begin
        entry_d = WAIT_TENS;
      end else if (rx_byte == SC_BKSP) begin
        case (entry_q)
          WAIT_ENTER: entry_d = WAIT_UNITS;
          WAIT_UNITS: entry_d = WAIT_TENS;
          default:    entry_d = entry_q;
        endcase
      end else if (is_digit(rx_byte)) begin
        case (entry_q)
          WAIT_TENS: begin
            tens_d  = rx_byte;
            entry_d = WAIT_UNITS;
          end
          WAIT_UNITS: begin
            units_d = rx_byte;
            entry_d = WAIT_ENTER;
          end
          default: units_d = rx_byte;
        endcase
      end else if (rx_byte == SC_ENTER && entry_q == WAIT_ENTER) begin
        dec_d   = tens_q;
        uni_d   = units_q;
        valid_d = 1'b1;
        entry_d = WAIT_TENS;
      end
    end
  end

  assign bus.DECENAS   = dec_q;
  assign bus.UNIDADES  = uni_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = rx_err;

endmodule

// File: tb/tb_ps2_temp_entry.sv
// Directed, table-driven bench for ps2_temp_entry: keystroke sequences with
// hand-computed committed pairs, plus parity/stop/timeout/glitch/reset cases.
module tb_ps2_temp_entry;

  localparam int HALF    = 20;
  localparam int GAP     = 60;
  localparam int TIMEOUT = 2000;

  typedef struct {
    int               n;
    logic [7:0][7:0]  codes;
    int               exp_valid;
    logic [7:0]       exp_dec;
    logic [7:0]       exp_uni;
  } vec_t;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   valid_cnt = 0;
  int   err_cnt = 0;
  int   valid_cyc = -1000;
  int   fall_cyc = 0;

  ps2_temp_entry_if bus();

  ps2_temp_entry #(.FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT)) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor: sampled on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (bus.valid === 1'b1) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
    end
    if (bus.frame_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (HALF) @(negedge CLK);
    bus.ps2_clk = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge CLK);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par = 1'b0, input logic stop = 1'b1);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ bad_par);
    ps2_bit(stop);
    bus.ps2_data = 1'b1;
    repeat (GAP) @(negedge CLK);
  endtask

  task automatic check_pair(input string tag, input logic [7:0] d, input logic [7:0] u);
    check({tag, " DECENAS"}, {24'h0, bus.DECENAS}, {24'h0, d});
    check({tag, " UNIDADES"}, {24'h0, bus.UNIDADES}, {24'h0, u});
  endtask

  function automatic vec_t mk(input int n,
                              input logic [7:0] c0, c1, c2, c3, c4, c5, c6, c7,
                              input int ev, input logic [7:0] d, input logic [7:0] u);
    vec_t v;
    v.n = n;
    v.codes = {c7, c6, c5, c4, c3, c2, c1, c0};
    v.exp_valid = ev;
    v.exp_dec = d;
    v.exp_uni = u;
    return v;
  endfunction

  vec_t vecs[8];
  int   v0, e0;

  initial begin
    vecs[0] = mk(7, 8'h1E, 8'hF0, 8'h1E, 8'h16, 8'hF0, 8'h16, 8'h5A, 8'h00, 1, 8'h1E, 8'h16);
    vecs[1] = mk(5, 8'h45, 8'h3D, 8'h66, 8'h25, 8'h5A, 8'h00, 8'h00, 8'h00, 1, 8'h45, 8'h25);
    vecs[2] = mk(3, 8'h36, 8'h76, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h45, 8'h25);
    vecs[3] = mk(7, 8'hE0, 8'h5A, 8'hF0, 8'h16, 8'h2E, 8'h36, 8'h5A, 8'h00, 1, 8'h2E, 8'h36);
    vecs[4] = mk(6, 8'h66, 8'h25, 8'h2E, 8'h3D, 8'h46, 8'h5A, 8'h00, 8'h00, 1, 8'h25, 8'h46);
    vecs[5] = mk(6, 8'h5A, 8'h1C, 8'h16, 8'h5A, 8'h1E, 8'h5A, 8'h00, 8'h00, 1, 8'h16, 8'h1E);
    vecs[6] = mk(5, 8'h3E, 8'h66, 8'h26, 8'h45, 8'h5A, 8'h00, 8'h00, 8'h00, 1, 8'h26, 8'h45);
    vecs[7] = mk(4, 8'h16, 8'h16, 8'h16, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h16, 8'h16);

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge CLK);
    reset = 1'b1;
    repeat (20) @(negedge CLK);
    check_pair("reset", 8'h00, 8'h00);
    check("reset valid", {31'h0, bus.valid}, 32'h0);
    check("reset frame_err", {31'h0, bus.frame_err}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      for (int k = 0; k < vecs[i].n; k++) send_frame(vecs[i].codes[k]);
      check($sformatf("vec%0d valid pulses", i), valid_cnt - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d frame_err pulses", i), err_cnt - e0, 0);
      check_pair($sformatf("vec%0d", i), vecs[i].exp_dec, vecs[i].exp_uni);
    end

    // No change before Enter, then commit 2 cycles after the stop-bit strobe.
    // The strobe itself trails the ps2_clk edge by 2 sync + 8 filter cycles.
    v0 = valid_cnt;
    send_frame(8'h45);
    send_frame(8'h2E);
    check("pre-enter valid pulses", valid_cnt - v0, 0);
    check_pair("pre-enter", 8'h16, 8'h16);
    send_frame(8'h5A);
    check("enter valid pulses", valid_cnt - v0, 1);
    check("enter latency in window", {31'h0, (valid_cyc - fall_cyc) >= 11 && (valid_cyc - fall_cyc) <= 13}, 32'h1);
    check_pair("enter", 8'h45, 8'h2E);

    // Parity error leaves the entry state alone.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'h45);
    send_frame(8'h46, 1'b1);
    check("parity frame_err pulses", err_cnt - e0, 1);
    check("parity valid pulses", valid_cnt - v0, 0);
    send_frame(8'h46);
    send_frame(8'h5A);
    check("after parity valid pulses", valid_cnt - v0, 1);
    check_pair("after parity", 8'h45, 8'h46);

    e0 = err_cnt;
    send_frame(8'h1E, 1'b0, 1'b0);
    check("stop-bit frame_err pulses", err_cnt - e0, 1);

    // Abort after four data bits and let the receiver time out.
    e0 = err_cnt;
    v0 = valid_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    bus.ps2_data = 1'b1;
    repeat (TIMEOUT + 200) @(negedge CLK);
    check("timeout frame_err pulses", err_cnt - e0, 1);
    send_frame(8'h3E);
    send_frame(8'h26);
    send_frame(8'h5A);
    check("after timeout valid pulses", valid_cnt - v0, 1);
    check("after timeout frame_err pulses", err_cnt - e0, 1);
    check_pair("after timeout", 8'h3E, 8'h26);

    // A 6 ns low glitch with data low must not look like a start bit.
    e0 = err_cnt;
    v0 = valid_cnt;
    bus.ps2_data = 1'b0;
    #2;
    bus.ps2_clk = 1'b0;
    #6;
    bus.ps2_clk = 1'b1;
    #2;
    bus.ps2_data = 1'b1;
    repeat (GAP) @(negedge CLK);
    send_frame(8'h1E);
    send_frame(8'h2E);
    send_frame(8'h5A);
    check("glitch valid pulses", valid_cnt - v0, 1);
    check("glitch frame_err pulses", err_cnt - e0, 0);
    check_pair("glitch", 8'h1E, 8'h2E);

    // Reset mid-frame with a tens digit pending.
    send_frame(8'h36);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    reset = 1'b0;
    #50;
    check_pair("in reset", 8'h00, 8'h00);
    reset = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (GAP) @(negedge CLK);
    check_pair("post reset", 8'h00, 8'h00);
    check("post reset valid", {31'h0, bus.valid}, 32'h0);
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'h16);
    send_frame(8'h5A);
    check("no partial entry valid pulses", valid_cnt - v0, 0);
    send_frame(8'h25);
    send_frame(8'h5A);
    check("post reset valid pulses", valid_cnt - v0, 1);
    check("post reset frame_err pulses", err_cnt - e0, 0);
    check_pair("post reset entry", 8'h16, 8'h25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
